qed_fetch_buffer: RTL

//  Fetch-response adapter between the QED instruction generator and the core's
//  64-bit instruction fetch port (mem_i_*). Buffers 32-bit instructions from QED
//  in a small FIFO, answers core fetch requests with one-cycle latency, packs each

---
 rtl/qed_fetch_buffer_if.sv | 23 ++
 rtl/qed_fetch_buffer.sv | 54 +++++
 2 files changed

// File: rtl/qed_fetch_buffer_if.sv
// qed_fetch_buffer_if: QED push side (in_*), core fetch port (mem_i_*) and response counter; master drives requests, slave is the buffer
interface qed_fetch_buffer_if;
  logic        in_valid_i;
  logic [31:0] in_inst_i;
  logic        in_ready_o;
  logic        mem_i_rd_i;
  logic        mem_i_flush_i;
  logic        mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o;
  logic        mem_i_valid_o;
  logic        mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic [31:0] resp_count_o;
  modport master (
    output in_valid_i, in_inst_i, mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    input  in_ready_o, mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o, resp_count_o
  );
  modport slave (
    input  in_valid_i, in_inst_i, mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    output in_ready_o, mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o, resp_count_o
  );
endinterface

// File: rtl/qed_fetch_buffer.sv
// qed_fetch_buffer: FIFO of QED instructions served to the 64-bit fetch port with 1-cycle latency, NOP-padded; ports clk_i, rst_i, bus (qed_fetch_buffer_if.slave)
module qed_fetch_buffer #(
  parameter int          DEPTH         = 4,
  parameter logic [31:0] NOP_INST      = 32'h00000013,
  parameter bit          DROP_ON_FLUSH = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  qed_fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, flush, push, pop, misaligned;
  logic [31:0] head;
  logic [63:0] word;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    flush = bus.mem_i_flush_i | bus.mem_i_invalidate_i;
    bus.in_ready_o = ~full & ~rst_i;
    bus.mem_i_accept_o = ~empty & ~flush & ~rst_i;
    push = bus.in_valid_i & bus.in_ready_o;
    pop = bus.mem_i_rd_i & bus.mem_i_accept_o;
    head = mem[rd_ptr[AW-1:0]];
    misaligned = |bus.mem_i_pc_i[1:0];
    word = misaligned ? {NOP_INST, NOP_INST} : bus.mem_i_pc_i[2] ? {head, NOP_INST} : {NOP_INST, head};
  end
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_inst_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.mem_i_valid_o <= 1'b0;
      bus.mem_i_error_o <= 1'b0;
      bus.mem_i_inst_o <= '0;
      bus.resp_count_o <= '0;
    end else begin
      bus.mem_i_valid_o <= pop;
      bus.mem_i_error_o <= pop & misaligned;
      bus.resp_count_o <= bus.resp_count_o + 32'(pop);
      if (pop) begin
        bus.mem_i_inst_o <= word;
        rd_ptr <= rd_ptr + ONE;
      end
      if (flush && DROP_ON_FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (push) wr_ptr <= wr_ptr + ONE;
    end
  end
endmodule
